// File: rtl/arb_req_queue.sv
// arb_req_queue: per-requestor packet FIFOs feeding an FCFS weighted
// round-robin arbiter. Presents req/weights from registered queue state
// and pops the granted head packet into a single registered output slot.
module arb_req_queue #(
  parameter int REQUESTORS = 4,
  parameter int DEPTH      = 4,
  parameter int DATA_W     = 8,
  parameter int TS_W       = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [REQUESTORS-1:0]        in_valid,
  output logic [REQUESTORS-1:0]        in_ready,
  input  logic [REQUESTORS*DATA_W-1:0] in_data,
  input  logic [REQUESTORS*2-1:0]      in_prio,
  output logic [REQUESTORS-1:0]        req,
  output logic [REQUESTORS*8-1:0]      weights,
  input  logic [REQUESTORS-1:0]        grant,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   out_id,
  output logic [DATA_W-1:0]            out_data,
  output logic [1:0]                   out_prio,
  output logic [TS_W-1:0]              out_wait,
  output logic                         err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_t;

  logic [DATA_W-1:0] mem_data_q [REQUESTORS][DEPTH];
  logic [DATA_W-1:0] mem_data_d [REQUESTORS][DEPTH];
  logic [1:0]        mem_prio_q [REQUESTORS][DEPTH];
  logic [1:0]        mem_prio_d [REQUESTORS][DEPTH];
  logic [TS_W-1:0]   mem_ts_q   [REQUESTORS][DEPTH];
  logic [TS_W-1:0]   mem_ts_d   [REQUESTORS][DEPTH];
  logic [PW-1:0]     wr_ptr_q   [REQUESTORS];
  logic [PW-1:0]     wr_ptr_d   [REQUESTORS];
  logic [PW-1:0]     rd_ptr_q   [REQUESTORS];
  logic [PW-1:0]     rd_ptr_d   [REQUESTORS];

  logic [TS_W-1:0]   ts_q, ts_d;
  slot_t             state_q, state_d;
  logic [7:0]        out_id_q, out_id_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [1:0]        out_prio_q, out_prio_d;
  logic [TS_W-1:0]   out_wait_q, out_wait_d;
  logic              err_q, err_d;

  logic [REQUESTORS-1:0] full, empty;
  logic                  grant_multi, grant_stray, grant_bad, slot_free, pop;
  logic [7:0]            sel_id;
  logic [DATA_W-1:0]     sel_data;
  logic [1:0]            sel_prio;
  logic [TS_W-1:0]       sel_ts;
  logic [1:0]            push_prio;

  // Occupancy, req/weights and ready decode from registered pointers only
  always_comb begin
    weights = '0;
    for (int unsigned i = 0; i < REQUESTORS; i++) begin
      empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      full[i]  = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                 (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
      if (!empty[i])
        weights[i*8 +: 8] = {6'd0, mem_prio_q[i][rd_ptr_q[i][AW-1:0]]} + 8'd1;
    end
    in_ready = ~full;
    req      = ~empty;
  end

  // Grant qualification, head-packet select and pop decision
  always_comb begin
    sel_id   = '0;
    sel_data = '0;
    sel_prio = '0;
    sel_ts   = '0;
    for (int unsigned i = 0; i < REQUESTORS; i++) begin
      if (grant[i]) begin
        sel_id   = 8'(i);
        sel_data = mem_data_q[i][rd_ptr_q[i][AW-1:0]];
        sel_prio = mem_prio_q[i][rd_ptr_q[i][AW-1:0]];
        sel_ts   = mem_ts_q[i][rd_ptr_q[i][AW-1:0]];
      end
    end
    grant_multi = (grant & (grant - 1'b1)) != '0;
    grant_stray = (grant & ~req) != '0;
    grant_bad   = grant_multi | grant_stray;
    slot_free   = (state_q == SLOT_EMPTY) | out_ready;
    pop         = !grant_bad && (grant != '0) && slot_free;
  end

  // Queue storage and pointer updates; push uses pre-pop fullness
  always_comb begin
    mem_data_d = mem_data_q;
    mem_prio_d = mem_prio_q;
    mem_ts_d   = mem_ts_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    push_prio  = '0;
    for (int unsigned i = 0; i < REQUESTORS; i++) begin
      if (in_valid[i] && !full[i]) begin
        push_prio = in_prio[i*2 +: 2];
        if (push_prio == 2'd3) push_prio = 2'd2;
        mem_data_d[i][wr_ptr_q[i][AW-1:0]] = in_data[i*DATA_W +: DATA_W];
        mem_prio_d[i][wr_ptr_q[i][AW-1:0]] = push_prio;
        mem_ts_d[i][wr_ptr_q[i][AW-1:0]]   = ts_q;
        wr_ptr_d[i] = wr_ptr_q[i] + PW'(1);
      end
      if (pop && grant[i])
        rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
    end
  end

  // Output slot FSM, output fields, timestamp and sticky error
  always_comb begin
    state_d    = state_q;
    out_id_d   = out_id_q;
    out_data_d = out_data_q;
    out_prio_d = out_prio_q;
    out_wait_d = out_wait_q;
    err_d      = err_q | grant_bad;
    ts_d       = ts_q + 1'b1;
    if (pop) begin
      state_d    = SLOT_FULL;
      out_id_d   = sel_id;
      out_data_d = sel_data;
      out_prio_d = sel_prio;
      out_wait_d = ts_q - sel_ts;
    end else if (state_q == SLOT_FULL && out_ready) begin
      state_d = SLOT_EMPTY;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < REQUESTORS; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
          mem_data_q[i][j] <= '0;
          mem_prio_q[i][j] <= '0;
          mem_ts_q[i][j]   <= '0;
        end
      end
      ts_q       <= '0;
      state_q    <= SLOT_EMPTY;
      out_id_q   <= '0;
      out_data_q <= '0;
      out_prio_q <= '0;
      out_wait_q <= '0;
      err_q      <= 1'b0;
    end else begin
      mem_data_q <= mem_data_d;
      mem_prio_q <= mem_prio_d;
      mem_ts_q   <= mem_ts_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ts_q       <= ts_d;
      state_q    <= state_d;
      out_id_q   <= out_id_d;
      out_data_q <= out_data_d;
      out_prio_q <= out_prio_d;
      out_wait_q <= out_wait_d;
      err_q      <= err_d;
    end
  end

  assign out_valid = (state_q == SLOT_FULL);
  assign out_id    = out_id_q;
  assign out_data  = out_data_q;
  assign out_prio  = out_prio_q;
  assign out_wait  = out_wait_q;
  assign err       = err_q;

endmodule

// File: tb/tb_arb_req_queue.sv
// Bench for arb_req_queue: queue-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
// A second instance with a 4-bit timestamp shares all inputs to exercise wrap.
module tb_arb_req_queue;

  logic        clk;
  logic        reset;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [7:0]  in_prio;
  logic [3:0]  grant;
  logic        out_ready;

  logic [3:0]  in_ready, req;
  logic [31:0] weights;
  logic        out_valid, err;
  logic [7:0]  out_id, out_data;
  logic [1:0]  out_prio;
  logic [31:0] out_wait;

  logic [3:0]  in_ready4, req4;
  logic [31:0] weights4;
  logic        out_valid4, err4;
  logic [7:0]  out_id4, out_data4;
  logic [1:0]  out_prio4;
  logic [3:0]  out_wait4;

  int checks = 0;
  int errors = 0;

  arb_req_queue #(.REQUESTORS(4), .DEPTH(4), .DATA_W(8), .TS_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_prio(in_prio), .req(req), .weights(weights),
    .grant(grant), .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_data(out_data), .out_prio(out_prio),
    .out_wait(out_wait), .err(err)
  );

  arb_req_queue #(.REQUESTORS(4), .DEPTH(4), .DATA_W(8), .TS_W(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_prio(in_prio), .req(req4), .weights(weights4),
    .grant(grant), .out_valid(out_valid4), .out_ready(out_ready),
    .out_id(out_id4), .out_data(out_data4), .out_prio(out_prio4),
    .out_wait(out_wait4), .err(err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0]  data;
    logic [1:0]  prio;
    logic [31:0] ts;
  } pkt_t;

  pkt_t        mq [4][$];
  logic        m_valid, m_err;
  logic [7:0]  m_id, m_data;
  logic [1:0]  m_prio;
  logic [31:0] m_wait, cnt;
  int          m_sz [4];
  logic [3:0]  m_rq;
  int          m_nb, m_g;
  logic        m_bad;
  pkt_t        m_p;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      m_valid = 1'b0; m_err = 1'b0; m_id = '0; m_data = '0;
      m_prio = '0; m_wait = '0; cnt = '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        m_sz[i] = mq[i].size();
        m_rq[i] = (m_sz[i] > 0);
      end
      m_nb  = $countones(grant);
      m_bad = (m_nb > 1) || ((grant & ~m_rq) != 4'd0);
      if (m_bad) m_err = 1'b1;
      if (!m_bad && m_nb == 1 && (!m_valid || out_ready)) begin
        m_g = 0;
        for (int i = 0; i < 4; i++) if (grant[i]) m_g = i;
        m_p     = mq[m_g].pop_front();
        m_valid = 1'b1;
        m_id    = 8'(m_g);
        m_data  = m_p.data;
        m_prio  = m_p.prio;
        m_wait  = cnt - m_p.ts;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        if (in_valid[i] && m_sz[i] < 4) begin
          m_p.data = in_data[i*8 +: 8];
          m_p.prio = (in_prio[i*2 +: 2] == 2'd3) ? 2'd2 : in_prio[i*2 +: 2];
          m_p.ts   = cnt;
          mq[i].push_back(m_p);
        end
      end
      cnt = cnt + 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [3:0]  e_ready, e_req;
  logic [31:0] e_w;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      e_ready[i]    = (mq[i].size() < 4);
      e_req[i]      = (mq[i].size() > 0);
      e_w[i*8 +: 8] = (mq[i].size() > 0) ? ({6'd0, mq[i][0].prio} + 8'd1) : 8'd0;
    end
    chk("in_ready", in_ready, e_ready);
    chk("req", req, e_req);
    chk("weights", weights, e_w);
    chk("out_valid", out_valid, m_valid);
    chk("err", err, m_err);
    chk("in_ready4", in_ready4, e_ready);
    chk("req4", req4, e_req);
    chk("weights4", weights4, e_w);
    chk("out_valid4", out_valid4, m_valid);
    chk("err4", err4, m_err);
    if (m_valid) begin
      chk("out_id", out_id, m_id);
      chk("out_data", out_data, m_data);
      chk("out_prio", out_prio, m_prio);
      chk("out_wait", out_wait, m_wait);
      chk("out_id4", out_id4, m_id);
      chk("out_data4", out_data4, m_data);
      chk("out_prio4", out_prio4, m_prio);
      chk("out_wait4", out_wait4, m_wait[3:0]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cnt(input logic [31:0] v, input logic [31:0] mask);
    int n = 0;
    while ((cnt & mask) != v && n < 200) begin
      tick();
      n++;
    end
    if ((cnt & mask) != v) chk("wait_cnt_timeout", cnt & mask, v);
  endtask

  initial begin
    reset = 1'b0; in_valid = '0; in_data = '0; in_prio = '0;
    grant = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Reset then idle
    tick(); tick();
    chk("idle_req", req, 4'b0000);
    chk("idle_weights", weights, 32'd0);
    chk("idle_out_valid", out_valid, 1'b0);
    chk("idle_err", err, 1'b0);
    chk("idle_in_ready", in_ready, 4'b1111);

    // Timestamp: push q1 at counter 5, pop at 12
    wait_cnt(32'd5, 32'hFFFF_FFFF);
    in_valid = 4'b0010; in_data = 32'h0000_A500; in_prio = 8'b0000_0000;
    tick();
    in_valid = '0;
    wait_cnt(32'd12, 32'hFFFF_FFFF);
    grant = 4'b0010;
    tick();
    grant = '0;
    chk("ts_out_valid", out_valid, 1'b1);
    chk("ts_out_id", out_id, 8'd1);
    chk("ts_out_wait", out_wait, 32'd7);
    tick();

    // Fill and drain queue 2 (MED)
    in_prio = 8'b0001_0000;
    for (int k = 0; k < 4; k++) begin
      in_valid = 4'b0100; in_data = 32'(8'h10 + k) << 16;
      tick();
    end
    in_valid = '0;
    chk("fill_in_ready2", in_ready[2], 1'b0);
    chk("fill_weight2", weights[23:16], 8'd2);
    grant = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("drain_data", out_data, 8'h10 + 8'(k));
      chk("drain_id", out_id, 8'd2);
    end
    chk("drain_req2", req[2], 1'b0);
    grant = '0;
    tick();

    // Back-pressure on queue 0 (prio 3 maps to HI)
    in_prio = 8'b0000_0011;
    for (int k = 0; k < 3; k++) begin
      in_valid = 4'b0001; in_data = 32'(8'h20 + k);
      tick();
    end
    in_valid = '0;
    chk("bp_weight0", weights[7:0], 8'd3);
    grant = 4'b0001;
    tick();
    chk("bp_first", out_data, 8'h20);
    chk("bp_prio", out_prio, 2'd2);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_hold_data", out_data, 8'h20);
      chk("bp_hold_err", err, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release", out_data, 8'h21);
    grant = '0;
    tick();
    chk("bp_empty", out_valid, 1'b0);

    // Timestamp wrap on the 4-bit instance: push at 14, pop at 3
    wait_cnt(32'd14, 32'hF);
    in_valid = 4'b0010; in_data = 32'h0000_5A00; in_prio = 8'b0000_0100;
    tick();
    in_valid = '0;
    wait_cnt(32'd3, 32'hF);
    grant = 4'b0010;
    tick();
    grant = '0;
    chk("wrap_out_wait4", out_wait4, 4'd5);
    chk("wrap_out_wait", out_wait, 32'd5);
    chk("wrap_data", out_data4, 8'h5A);
    tick();

    // Protocol errors: multi-bit grant, then grant to empty queue 3
    grant = 4'b0011;
    tick();
    chk("perr_multi_err", err, 1'b1);
    chk("perr_multi_nopop", out_valid, 1'b0);
    chk("perr_req0", req[0], 1'b1);
    grant = 4'b1000;
    tick();
    grant = '0;
    chk("perr_empty_err", err, 1'b1);
    chk("perr_empty_nopop", out_valid, 1'b0);
    chk("perr_weight0", weights[7:0], 8'd3);

    // Collision on full queue 0, then reset mid-drain
    in_prio = 8'b0000_0000;
    for (int k = 0; k < 3; k++) begin
      in_valid = 4'b0001; in_data = 32'(8'h30 + k);
      tick();
    end
    chk("col_full", in_ready[0], 1'b0);
    in_valid = 4'b0001; in_data = 32'h0000_0099; grant = 4'b0001;
    tick();
    in_valid = '0;
    chk("col_pop_data", out_data, 8'h22);
    chk("col_ready_back", in_ready[0], 1'b1);
    tick();
    chk("col_next", out_data, 8'h30);
    #3 reset = 1'b0; grant = '0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_req", req, 4'b0000);
    chk("rst_ts", dut.ts_q, 32'd0);
    chk("rst_err", err, 1'b0);
    tick(); tick();
    reset = 1'b1;
    repeat (3) tick();
    chk("post_rst_valid", out_valid, 1'b0);
    chk("post_rst_req", req, 4'b0000);
    in_valid = 4'b1000; in_data = 32'h7700_0000;
    tick();
    in_valid = '0; grant = 4'b1000;
    tick();
    grant = '0;
    chk("post_rst_data", out_data, 8'h77);
    chk("post_rst_id", out_id, 8'd3);
    chk("post_rst_prio", out_prio, 2'd0);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
